pwm_multi_core: RTL

- Parametrised successor PWM timer core: N channels, configurable counter width, edge- or center-aligned counting.
- Per-channel output polarity and shadowed (double-buffered) configuration, applied at period boundary.
- Runs on a single clock: the prescaler is a clock-enable, with no derived clock and no CDC.
- Sits behind an APB4 register wrapper, which drives the config inputs and consumes ov_o as the interrupt source.

---
 rtl/pwm_multi_core_if.sv | 40 ++++
 rtl/pwm_multi_core.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_core_if.sv
// Configuration and status bundle between the APB register wrapper (master) and pwm_multi_core (slave).
// PWM_ONE_PULSE_EN adds the one_pulse_i configuration signal.
interface pwm_multi_core_if #(
  parameter int unsigned CHNL_NUM   = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PSCR_WIDTH = 16
);
  logic                          en_i;
  logic                          mode_i;
  logic [PSCR_WIDTH-1:0]         pscr_i;
  logic [CNT_WIDTH-1:0]          cmp_i;
  logic [CHNL_NUM*CNT_WIDTH-1:0] crx_i;
  logic [CHNL_NUM-1:0]           pol_i;
  logic                          upd_i;
`ifdef PWM_ONE_PULSE_EN
  logic                          one_pulse_i;
`endif
  logic                          upd_pend_o;
  logic [CNT_WIDTH-1:0]          cnt_o;
  logic                          dir_o;
  logic                          ov_o;
  logic                          busy_o;
  logic [CHNL_NUM-1:0]           pwm_o;

  modport master (
`ifdef PWM_ONE_PULSE_EN
    output one_pulse_i,
`endif
    output en_i, mode_i, pscr_i, cmp_i, crx_i, pol_i, upd_i,
    input  upd_pend_o, cnt_o, dir_o, ov_o, busy_o, pwm_o
  );

  modport slave (
`ifdef PWM_ONE_PULSE_EN
    input  one_pulse_i,
`endif
    input  en_i, mode_i, pscr_i, cmp_i, crx_i, pol_i, upd_i,
    output upd_pend_o, cnt_o, dir_o, ov_o, busy_o, pwm_o
  );
endinterface

// File: rtl/pwm_multi_core.sv
// Multi-channel PWM timer core: prescaled edge/center-aligned counter, shadowed config, registered outputs.
// Optional one-pulse mode is enabled by defining PWM_ONE_PULSE_EN.
module pwm_multi_core #(
  parameter int unsigned CHNL_NUM   = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PSCR_WIDTH = 16
) (
  input logic              clk_i,
  input logic              rst_n_i,
  pwm_multi_core_if.slave  bus
);

  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [PSCR_WIDTH-1:0] pscr_t;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  logic                mode_a;
  pscr_t               pscr_a;
  cnt_t                cmp_a;
  cnt_t                crx_a [CHNL_NUM];
  logic [CHNL_NUM-1:0] pol_a;

  pscr_t               pscr_cnt;
  cnt_t                cnt, cnt_nxt;
  dir_e                dir, dir_nxt;
  logic                pend, pend_nxt;
  logic                ov;
  logic [CHNL_NUM-1:0] pwm, raw;
  logic                tick, boundary, wrap, load;
  logic                stopped, stop_now;

  always_comb begin
    tick     = bus.en_i & ~stopped & (pscr_cnt == pscr_a);
    pend_nxt = pend | bus.upd_i;
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    // cnt above a freshly shrunk cmp_a is treated as if it sat exactly on cmp_a
    if (cmp_a == '0) begin
      cnt_nxt  = '0;
      dir_nxt  = DIR_UP;
      boundary = 1'b1;
    end else if (!mode_a) begin
      dir_nxt = DIR_UP;
      if (cnt >= cmp_a) begin
        cnt_nxt  = '0;
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt + cnt_t'(1);
      end
    end else if (dir == DIR_UP) begin
      if (cnt >= cmp_a) begin
        dir_nxt = DIR_DOWN;
        cnt_nxt = cmp_a - cnt_t'(1);
      end else begin
        cnt_nxt = cnt + cnt_t'(1);
      end
    end else begin
      if (cnt == '0) begin
        dir_nxt  = DIR_UP;
        cnt_nxt  = cnt_t'(1);
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt - cnt_t'(1);
      end
    end
    wrap = tick & boundary;
    load = ~bus.en_i | (wrap & pend_nxt);
  end

  always_comb begin
    raw = '0;
    for (int unsigned k = 0; k < CHNL_NUM; k++) begin
      raw[k] = (cnt < crx_a[k]);
    end
  end

`ifdef PWM_ONE_PULSE_EN
  logic one_pulse_a;

  assign stop_now = wrap & one_pulse_a;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      one_pulse_a <= 1'b0;
      stopped     <= 1'b0;
    end else begin
      if (load) begin
        one_pulse_a <= bus.one_pulse_i;
      end
      if (!bus.en_i) begin
        stopped <= 1'b0;
      end else if (stop_now) begin
        stopped <= 1'b1;
      end
    end
  end
`else
  assign stop_now = 1'b0;
  assign stopped  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_a   <= 1'b0;
      pscr_a   <= '0;
      cmp_a    <= '0;
      pol_a    <= '0;
      for (int unsigned k = 0; k < CHNL_NUM; k++) begin
        crx_a[k] <= '0;
      end
      pscr_cnt <= '0;
      cnt      <= '0;
      dir      <= DIR_UP;
      pend     <= 1'b0;
      ov       <= 1'b0;
      pwm      <= '0;
    end else begin
      if (load) begin
        mode_a <= bus.mode_i;
        pscr_a <= bus.pscr_i;
        cmp_a  <= bus.cmp_i;
        pol_a  <= bus.pol_i;
        for (int unsigned k = 0; k < CHNL_NUM; k++) begin
          crx_a[k] <= bus.crx_i[k*CNT_WIDTH +: CNT_WIDTH];
        end
      end
      if (!bus.en_i) begin
        pscr_cnt <= '0;
        cnt      <= '0;
        dir      <= DIR_UP;
        pend     <= 1'b0;
        ov       <= 1'b0;
        pwm      <= bus.pol_i;
      end else begin
        ov   <= wrap;
        pwm  <= raw ^ pol_a;
        pend <= wrap ? 1'b0 : pend_nxt;
        if (tick) begin
          pscr_cnt <= '0;
          // stopping, or loading edge mode, restarts from the boundary state cnt=0
          if (stop_now || (wrap && pend_nxt && !bus.mode_i)) begin
            cnt <= '0;
            dir <= DIR_UP;
          end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
          end
        end else if (!stopped) begin
          pscr_cnt <= pscr_cnt + pscr_t'(1);
        end
      end
    end
  end

  assign bus.upd_pend_o = pend;
  assign bus.cnt_o      = cnt;
  assign bus.dir_o      = (dir == DIR_UP);
  assign bus.ov_o       = ov;
  assign bus.busy_o     = bus.en_i & ~stopped & rst_n_i;
  assign bus.pwm_o      = pwm;

endmodule
